// File: rtl/clk_tick_pkg.sv
// Shared constants and helpers for the clk_tick_gen phase-accumulator divider.
package clk_tick_pkg;

   localparam int unsigned DefChannels = 4;
   localparam int unsigned DefWidth    = 16;
   localparam int unsigned CntWidth    = 16;

   // Address width for a channel index, never narrower than one bit.
   function automatic int unsigned addr_width(input int unsigned n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/clk_tick_gen_if.sv
// Control/status bundle for clk_tick_gen.
// Counter ports exist only when CLK_TICK_GEN_CNT_EN is defined.
interface clk_tick_gen_if
   import clk_tick_pkg::*;
#(
   parameter int unsigned CHANNELS = DefChannels,
   parameter int unsigned WIDTH    = DefWidth
);
   localparam int unsigned AW = addr_width(CHANNELS);

   logic [CHANNELS-1:0] EN;
   logic                SYNC;
   logic                WR_EN;
   logic [AW-1:0]       WR_ADDR;
   logic [WIDTH-1:0]    WR_DATA;
   logic [CHANNELS-1:0] TICK;
   logic [CHANNELS-1:0] CLK_OUT;
   logic [CHANNELS-1:0] PENDING;
`ifdef CLK_TICK_GEN_CNT_EN
   logic [AW-1:0]       CNT_ADDR;
   logic                CNT_CLR;
   logic [CntWidth-1:0] CNT_DATA;
`endif

   modport master (
      output EN, SYNC, WR_EN, WR_ADDR, WR_DATA,
`ifdef CLK_TICK_GEN_CNT_EN
      output CNT_ADDR, CNT_CLR,
      input  CNT_DATA,
`endif
      input  TICK, CLK_OUT, PENDING
   );

   modport slave (
      input  EN, SYNC, WR_EN, WR_ADDR, WR_DATA,
`ifdef CLK_TICK_GEN_CNT_EN
      input  CNT_ADDR, CNT_CLR,
      output CNT_DATA,
`endif
      output TICK, CLK_OUT, PENDING
   );

endinterface

// File: rtl/clk_tick_chan.sv
// One divider channel: phase accumulator with active/shadow increment.
// Optional saturating tick counter under CLK_TICK_GEN_CNT_EN.
module clk_tick_chan
   import clk_tick_pkg::*;
#(
   parameter int unsigned WIDTH     = DefWidth,
   parameter int unsigned RESET_INC = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                en,
   input  logic                sync,
   input  logic                wr_hit,
   input  logic [WIDTH-1:0]    wr_data,
`ifdef CLK_TICK_GEN_CNT_EN
   input  logic                cnt_clr,
   output logic [CntWidth-1:0] cnt,
`endif
   output logic                tick,
   output logic                clk_out,
   output logic                pending
);

   localparam logic [WIDTH-1:0] ResetInc = WIDTH'(RESET_INC);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic [WIDTH:0]   sum;

   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, act_q};
      acc_d  = acc_q;
      act_d  = act_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      if (sync) begin
         acc_d  = '0;
         pend_d = 1'b0;
         if (wr_hit) begin
            act_d = wr_data;
            sh_d  = wr_data;
         end else if (pend_q) begin
            act_d = sh_q;
         end
      end else begin
         if (en) begin
            acc_d  = sum[WIDTH-1:0];
            tick_d = sum[WIDTH];
         end
         // A fresh write always wins over a shadow that would apply this edge.
         if (wr_hit) begin
            sh_d   = wr_data;
            pend_d = 1'b1;
         end else if (pend_q && (sum[WIDTH] || !en)) begin
            act_d  = sh_q;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         acc_q  <= '0;
         act_q  <= ResetInc;
         sh_q   <= ResetInc;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         act_q  <= act_d;
         sh_q   <= sh_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
      end
   end

`ifdef CLK_TICK_GEN_CNT_EN
   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (tick_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
`endif

   assign tick    = tick_q;
   assign clk_out = acc_q[WIDTH-1];
   assign pending = pend_q;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel fractional tick/clock generator built from clk_tick_chan.
// Define CLK_TICK_GEN_CNT_EN to add per-channel tick counters and a readback port.
module clk_tick_gen
   import clk_tick_pkg::*;
#(
   parameter int unsigned CHANNELS  = DefChannels,
   parameter int unsigned WIDTH     = DefWidth,
   parameter int unsigned RESET_INC = 1
) (
   input logic           CLK,
   input logic           RST,
   clk_tick_gen_if.slave bus
);

   localparam int unsigned AW = addr_width(CHANNELS);

   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] tick_v;
   logic [CHANNELS-1:0] clk_out_v;
   logic [CHANNELS-1:0] pend_v;

`ifdef CLK_TICK_GEN_CNT_EN
   logic [CntWidth-1:0] cnt_arr [CHANNELS];
   logic [CHANNELS-1:0] cnt_clr;
   logic [CntWidth-1:0] cnt_data_q;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      // Out-of-range addresses match no channel, so such writes fall away.
      assign wr_hit[i] = bus.WR_EN && (bus.WR_ADDR == AW'(i));
`ifdef CLK_TICK_GEN_CNT_EN
      assign cnt_clr[i] = bus.CNT_CLR && (bus.CNT_ADDR == AW'(i));
`endif

      clk_tick_chan #(
         .WIDTH     (WIDTH),
         .RESET_INC (RESET_INC)
      ) u_chan (
         .CLK     (CLK),
         .RST     (RST),
         .en      (bus.EN[i]),
         .sync    (bus.SYNC),
         .wr_hit  (wr_hit[i]),
         .wr_data (bus.WR_DATA),
`ifdef CLK_TICK_GEN_CNT_EN
         .cnt_clr (cnt_clr[i]),
         .cnt     (cnt_arr[i]),
`endif
         .tick    (tick_v[i]),
         .clk_out (clk_out_v[i]),
         .pending (pend_v[i])
      );
   end

`ifdef CLK_TICK_GEN_CNT_EN
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_data_q <= '0;
      end else if (32'(bus.CNT_ADDR) < CHANNELS) begin
         cnt_data_q <= cnt_arr[bus.CNT_ADDR];
      end else begin
         cnt_data_q <= '0;
      end
   end

   assign bus.CNT_DATA = cnt_data_q;
`endif

   assign bus.TICK    = tick_v;
   assign bus.CLK_OUT = clk_out_v;
   assign bus.PENDING = pend_v;

endmodule

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the phase accumulator width in bits (4..32).
REQ-003 The block SHALL have parameter RESET_INC, default 1, giving the increment loaded into every channel at reset.
REQ-004 The block SHALL have port CLK  in  1  single clock; all logic on the rising edge.
REQ-005 The block SHALL have port RST  in  1  reset; synchronous, active-low.
REQ-006 The block SHALL have port EN  in  CHANNELS  per-channel accumulate enable.
REQ-007 The block SHALL have port SYNC  in  1  phase-restart strobe for all channels.
REQ-008 The block SHALL have port WR_EN  in  1  increment write strobe.
REQ-009 The block SHALL have port WR_ADDR  in  clog2(CHANNELS) (min 1)  target channel.
REQ-010 The block SHALL have port WR_DATA  in  WIDTH  new increment value.
REQ-011 The block SHALL have port TICK  out  CHANNELS  one-cycle pulse per accumulator wrap.
REQ-012 The block SHALL have port CLK_OUT  out  CHANNELS  accumulator MSB, a near-square output.
REQ-013 The block SHALL have port PENDING  out  CHANNELS  shadow increment not yet applied.

Function
REQ-014 On each edge with EN[i]=1, channel i SHALL compute {carry, acc} = acc + inc_active, unsigned (WIDTH+1 bits), register acc, and set TICK[i]=carry and CLK_OUT[i]=new acc[WIDTH-1] on that same edge.
REQ-015 On each edge with EN[i]=0, channel i SHALL hold acc and CLK_OUT[i] and drive TICK[i]=0.
REQ-016 The long-run TICK rate SHALL be exactly inc_active/2^WIDTH ticks per enabled cycle; inc_active=0 SHALL freeze the channel with no ticks.
REQ-017 A write (WR_EN=1) SHALL load WR_DATA into inc_shadow of channel WR_ADDR and set PENDING for that channel; writes with WR_ADDR >= CHANNELS SHALL be ignored.
REQ-018 A pending shadow SHALL become inc_active on the first edge after the write at which the channel wraps (carry=1), or on the next edge if EN[i]=0; PENDING SHALL clear on that edge.
REQ-019 A write while PENDING is set SHALL overwrite inc_shadow, with PENDING remaining set.
REQ-020 A write coinciding with a wrap of the same channel SHALL leave the written value pending; the older shadow SHALL be discarded.
REQ-021 SYNC=1 SHALL, on that edge, clear acc, TICK and CLK_OUT of every channel, apply every pending shadow immediately, and clear PENDING; SYNC SHALL override EN, and a simultaneous write SHALL be applied as active directly.

Reset
REQ-022 With RST=0 at an edge: acc=0, inc_active=inc_shadow=RESET_INC, TICK=0, CLK_OUT=0, PENDING=0, tick counters=0, for all channels.
REQ-023 Reset SHALL take priority over SYNC, WR_EN and EN, and SHALL abort any pending update.

Configuration
REQ-024 With macro CLK_TICK_GEN_CNT_EN defined, the block SHALL add ports CNT_ADDR (in, clog2(CHANNELS)), CNT_CLR (in, 1) and CNT_DATA (out, 16); each channel SHALL keep a 16-bit count of TICKs that saturates at 0xFFFF.
REQ-025 With CLK_TICK_GEN_CNT_EN defined, CNT_DATA SHALL present the count of channel CNT_ADDR, registered with one-cycle latency, and CNT_CLR=1 SHALL zero that channel's count; a coincident tick SHALL be lost.
REQ-026 Without CLK_TICK_GEN_CNT_EN, these ports and counters SHALL be absent, with all other behaviour unchanged.

Structure
REQ-027 Package clk_tick_pkg SHALL hold the default WIDTH/CHANNELS constants, the counter width (16), and the address-width function.
REQ-028 Per-channel logic (accumulator, active/shadow increment, pending, optional counter) SHALL be a sub-module clk_tick_chan, instantiated CHANNELS times.

Verification (WIDTH=8, CHANNELS=4)
REQ-029 Scenario: after reset, EN=0001, with no writes -> TICK[0] high exactly once every 256 cycles, and CLK_OUT[0] 128 cycles low then 128 high.
REQ-030 Scenario: write inc=64 to ch1 with EN[1]=0, then EN[1]=1 -> PENDING[1] clears next edge; TICK[1] every 4th cycle; CLK_OUT[1] 2 high/2 low.
REQ-031 Scenario: ch0 active inc=1, acc=10, write inc=128 -> PENDING[0] stays set for 246 cycles until the wrap, then TICK[0] every 2 cycles.
REQ-032 Scenario: inc=3 on ch2 for 2560 enabled cycles -> exactly 30 ticks; write inc=0 -> no further ticks, and CLK_OUT[2] holds.
REQ-033 Scenario: SYNC mid-run on all channels with a write to ch3 in the same cycle -> all acc=0, CLK_OUT=0, PENDING=0, and ch3 runs at the new increment immediately.
REQ-034 Scenario: RST=0 mid-run with PENDING set; with CLK_TICK_GEN_CNT_EN, count at 0xFFFF -> all outputs match REQ-022, count reads 0; a separate run confirms saturation holds at 0xFFFF.
